// File: rtl/kem_sample_ntt.sv
// kem_sample_ntt: SampleNTT rejection sampler. Pulls SHAKE128 rate blocks,
// scans one 3-byte group per cycle and packs accepted 12-bit values into an
// NTT-domain polynomial.
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | block_ready_o high, waiting for a squeeze block
// SCAN  | decoding one group per cycle from the byte buffer
// DONE  | done_o pulse, polynomial complete
module kem_sample_ntt #(
  parameter int Q          = 3329,
  parameter int LEN_Q      = 12,
  parameter int RATE_BYTES = 168
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [4:0][4:0][63:0]       block_i,
  input  logic                        block_valid_i,
  output logic                        block_ready_o,
  output logic [255:0][LEN_Q-1:0]     poly_o,
  output logic                        done_o,
  output logic                        busy_o
);

  localparam int G         = RATE_BYTES / 3;
  localparam int RATE_BITS = RATE_BYTES * 8;
  localparam int LANES     = RATE_BYTES / 8;
  localparam int JW        = $clog2(G);
  localparam logic [11:0]   Q_C    = 12'(Q);
  localparam logic [JW-1:0] J_LAST = JW'(G - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

  state_t               state;
  logic [8:0]           cnt;
  logic [JW-1:0]        j;
  logic [RATE_BITS-1:0] blk_buf;
  logic [RATE_BITS-1:0] rate_bits;

  logic [7:0]  b0, b1, b2;
  logic [11:0] d1, d2;
  logic        a1, a2;
  logic [8:0]  cnt_a1, cnt_next;

  // Capacity lanes stay inside the permutation; only rate lanes are sampled.
  logic unused_cap;
  assign unused_cap = ^block_i[4][4:1];

  // Flatten rate lanes into byte order: lane i = x + 5y holds bytes 8i..8i+7.
  always_comb begin
    rate_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      rate_bits[64*i +: 64] = block_i[i/5][i%5];
    end
  end

  // Decode the current group; the buffer shifts so group j is always at the bottom.
  always_comb begin
    b0       = blk_buf[7:0];
    b1       = blk_buf[15:8];
    b2       = blk_buf[23:16];
    d1       = {b1[3:0], b0};
    d2       = {b2, b1[7:4]};
    a1       = (d1 < Q_C);
    cnt_a1   = cnt + {8'd0, a1};
    a2       = (d2 < Q_C) && !cnt_a1[8];
    cnt_next = cnt_a1 + {8'd0, a2};
  end

  // Sequencer: state, counters, buffer, coefficient writes and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      j             <= '0;
      blk_buf       <= '0;
      poly_o        <= '0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      block_ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt           <= '0;
            poly_o        <= '0;
            busy_o        <= 1'b1;
            block_ready_o <= 1'b1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (block_valid_i) begin
            blk_buf       <= rate_bits;
            j             <= '0;
            block_ready_o <= 1'b0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (a1) poly_o[cnt[7:0]] <= d1;
          if (a2) poly_o[cnt_a1[7:0]] <= d2;
          cnt     <= cnt_next;
          blk_buf <= blk_buf >> 24;
          if (cnt_next[8]) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (j == J_LAST) begin
            block_ready_o <= 1'b1;
            state         <= FETCH;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kem_sample_ntt.sv
// Scoreboard bench for kem_sample_ntt: a SampleNTT reference model fills an
// expectation queue per start; a negedge monitor checks each done_o.
module tb_kem_sample_ntt;

  localparam int Q    = 3329;
  localparam int RB   = 168;
  localparam int MAXB = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic [4:0][4:0][63:0] block_i;
  logic                  block_valid_i;
  logic                  block_ready_o;
  logic [255:0][11:0]    poly_o;
  logic                  done_o;
  logic                  busy_o;

  kem_sample_ntt dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .block_i       (block_i),
    .block_valid_i (block_valid_i),
    .block_ready_o (block_ready_o),
    .poly_o        (poly_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [255:0][11:0] c;
    logic [7:0]         nb;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stream [MAXB*RB];
  int         hs_log[$];
  int checks = 0, errors = 0;
  int t0 = 0, hs_cnt = 0, ready_cnt = 0;
  int last_hs_cnt = 0, last_ready_cnt = 0, last_done_time = 0, done_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference SampleNTT over the byte stream; nb = blocks consumed, -1 if too few.
  function automatic void model(output logic [255:0][11:0] p, output int nb);
    int n = 0;
    int g = 0;
    int v1, v2;
    p = '0;
    while (n < 256 && g < MAXB*RB/3) begin
      v1 = stream[3*g] + 256 * (stream[3*g+1] % 16);
      v2 = stream[3*g+1] / 16 + 16 * stream[3*g+2];
      if (v1 < Q) begin p[n] = 12'(v1); n++; end
      if (v2 < Q && n < 256) begin p[n] = 12'(v2); n++; end
      g++;
    end
    nb = (n < 256) ? -1 : (g - 1) / (RB/3) + 1;
  endfunction

  function automatic logic [4:0][4:0][63:0] pack(input int k);
    logic [4:0][4:0][63:0] b;
    for (int i = 0; i < 25; i++)
      for (int kk = 0; kk < 8; kk++)
        b[i/5][i%5][8*kk +: 8] = (i < 21) ? stream[k*RB + 8*i + kk] : 8'($urandom);
    return b;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < MAXB*RB; i++) stream[i] = v;
  endtask

  task automatic fill_random();
    logic [255:0][11:0] p;
    int nb;
    do begin
      for (int i = 0; i < MAXB*RB; i++) stream[i] = 8'($urandom);
      model(p, nb);
    end while (nb < 0);
  endtask

  // Issue one start and feed exactly the blocks the model says are needed.
  task automatic run_poly(input int gap_max);
    exp_t e;
    int   nb, n, gap, d0;
    logic hs;
    model(e.c, nb);
    e.nb = 8'(nb);
    exp_q.push_back(e);
    d0 = done_seen;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < nb; k++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (gap > 0) begin
        block_valid_i = 1'b0;
        repeat (gap) tick();
      end
      block_i = pack(k);
      block_valid_i = 1'b1;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 2000) begin
        hs = block_ready_o;
        tick();
        n++;
      end
      if (!hs) check("handshake_timeout", 0, 1);
      if (gap_max > 0) block_valid_i = 1'b0;
    end
    block_valid_i = 1'b0;
    n = 0;
    while (busy_o && n < 300) begin
      tick();
      n++;
    end
    check("poly_completes", busy_o, 0);
    check("done_pulses_once", done_seen - d0, 1);
  endtask

  // Monitor: observe handshakes and done_o, compare against the queued model result.
  always @(negedge clk) begin : mon
    exp_t e;
    int nbad, first;
    if (!rst) begin
      if (start_i && !busy_o) begin
        t0 = cyc; hs_cnt = 0; ready_cnt = 0;
      end
      if (block_ready_o) ready_cnt++;
      if (block_ready_o && block_valid_i) begin
        hs_cnt++;
        hs_log.push_back(cyc - t0);
      end
      if (done_o) begin
        done_seen++;
        last_done_time = cyc - t0;
        last_hs_cnt    = hs_cnt;
        last_ready_cnt = ready_cnt;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_o at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          nbad = 0;
          first = -1;
          for (int k = 0; k < 256; k++)
            if (poly_o[k] !== e.c[k]) begin
              nbad++;
              if (first < 0) first = k;
            end
          checks++;
          if (nbad > 0) begin
            errors++;
            $display("FAIL poly_match: %0d coeffs differ, first k=%0d got %0d expected %0d",
                     nbad, first, poly_o[first], e.c[first]);
          end
          check("blocks_per_poly", hs_cnt, e.nb);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; start_i = 1'b0; block_valid_i = 1'b0; block_i = '0;
    fill_const(8'h00);
    tick(); tick();
    check("reset_busy", busy_o, 0);
    check("reset_ready", block_ready_o, 0);
    check("reset_done", done_o, 0);
    check("reset_poly_zero", poly_o == '0, 1);
    rst = 1'b0;
    tick();

    // All-zero blocks, valid held high.
    fill_const(8'h00);
    hs_log.delete();
    run_poly(0);
    check("zero_hs_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("zero_hs0", hs_log[0], 1);
      check("zero_hs1", hs_log[1], 58);
      check("zero_hs2", hs_log[2], 115);
    end
    check("zero_done_cycle", last_done_time, 132);
    check("zero_ready_cycles", last_ready_cnt, 3);
    check("zero_poly", poly_o == '0, 1);

    // First group 01 23 45.
    fill_const(8'h00);
    stream[0] = 8'h01; stream[1] = 8'h23; stream[2] = 8'h45;
    run_poly(0);
    check("grp_coef0", poly_o[0], 769);
    check("grp_coef1", poly_o[1], 1106);
    check("grp_coef2", poly_o[2], 0);

    // Boundary group 00 1D D0: d1 = 3328 accepted, d2 = 3329 rejected.
    for (int i = 0; i < MAXB*RB; i += 3) begin
      stream[i] = 8'h00; stream[i+1] = 8'h1D; stream[i+2] = 8'hD0;
    end
    run_poly(0);
    check("bnd_blocks", last_hs_cnt, 5);
    check("bnd_coef0", poly_o[0], 3328);
    check("bnd_coef255", poly_o[255], 3328);
    check("bnd_done_cycle", last_done_time, 262);

    // Odd-count boundary: cnt reaches 255, then a group with both values valid.
    fill_const(8'h00);
    stream[381] = 8'h00; stream[382] = 8'h1D; stream[383] = 8'hD0;
    stream[384] = 8'h05; stream[385] = 8'h00; stream[386] = 8'h01;
    run_poly(0);
    check("odd_coef255", poly_o[255], 5);
    check("odd_coef254", poly_o[254], 3328);
    check("odd_coef253", poly_o[253], 0);
    check("odd_done_cycle", last_done_time, 133);

    // All-0xFF blocks, a stray start while busy, then reset in SCAN.
    fill_const(8'hFF);
    hs_log.delete();
    d0 = done_seen;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    block_i = pack(0);
    block_valid_i = 1'b1;
    for (int c = 2; c <= 150; c++) begin
      tick();
      start_i = (c == 30);
    end
    check("ff_hs_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("ff_hs0", hs_log[0], 1);
      check("ff_hs1", hs_log[1], 58);
      check("ff_hs2", hs_log[2], 115);
    end
    check("ff_still_busy", busy_o, 1);
    check("ff_no_done", done_seen - d0, 0);
    check("ff_poly_zero", poly_o == '0, 1);
    rst = 1'b1;
    block_valid_i = 1'b0;
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_ready", block_ready_o, 0);
    check("rst_done", done_o, 0);
    rst = 1'b0;
    tick();

    // Reset mid-SCAN with random data must clear written coefficients.
    fill_random();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    block_i = pack(0);
    block_valid_i = 1'b1;
    tick();
    block_valid_i = 1'b0;
    repeat (10) tick();
    check("pre_rst_poly_nonzero", poly_o != '0, 1);
    rst = 1'b1;
    tick();
    check("rst2_poly_zero", poly_o == '0, 1);
    check("rst2_busy", busy_o, 0);
    check("rst2_ready", block_ready_o, 0);
    rst = 1'b0;
    tick();

    // Random data with backpressure gaps.
    for (int r = 0; r < 12; r++) begin
      fill_random();
      run_poly(20);
      tick();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
